div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 20 ++
 rtl/div_ctrl.sv | 95 +++++++++
 tb/tb_div_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared encodings for the execute-stage divide controller: FSM states and
// the handshake levels exchanged with the iterative divider.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_DONE   = 2'b10,
        ST_CANCEL = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // CANCEL lasts two cycles; the counter runs 0..CANCEL_LAST.
    localparam logic [1:0] CANCEL_LAST = 2'd1;

endpackage

// File: rtl/div_ctrl.sv
// Execute-stage controller for DIV/DIVU: holds the pipeline while the external
// divider works, then strobes the remainder/quotient into HI/LO once.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_div_valid,
    input  logic                ex_div_signed,
    input  logic [DATA_W-1:0]   ex_opa,
    input  logic [DATA_W-1:0]   ex_opb,
    input  logic                flush_i,
    output logic                stall_req_o,
    output logic                div_start_o,
    output logic                div_annul_o,
    output logic                div_signed_o,
    output logic [DATA_W-1:0]   div_op1_o,
    output logic [DATA_W-1:0]   div_op2_o,
    input  logic [2*DATA_W-1:0] div_result_i,
    input  logic                div_ready_i,
    output logic                hilo_we_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o
);

    div_state_e state;
    logic [1:0] cancel_cnt;
    logic       done_q;
    logic       issue;

    assign issue = (state == ST_IDLE) && ex_div_valid && !flush_i;

    // Stall must rise in the issue cycle itself, before the registered start.
    assign stall_req_o = (div_start_o == DivStart) || issue;
    assign hilo_we_o   = done_q && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cancel_cnt   <= 2'd0;
            done_q       <= 1'b0;
            div_start_o  <= DivStop;
            div_annul_o  <= 1'b0;
            div_signed_o <= 1'b0;
            div_op1_o    <= '0;
            div_op2_o    <= '0;
            hi_o         <= '0;
            lo_o         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        div_op1_o    <= ex_opa;
                        div_op2_o    <= ex_opb;
                        div_signed_o <= ex_div_signed;
                        div_start_o  <= DivStart;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A flush wins over a result arriving in the same cycle.
                    if (flush_i) begin
                        div_start_o <= DivStop;
                        div_annul_o <= 1'b1;
                        cancel_cnt  <= 2'd0;
                        state       <= ST_CANCEL;
                    end else if (div_ready_i == DivResultReady) begin
                        hi_o        <= div_result_i[2*DATA_W-1:DATA_W];
                        lo_o        <= div_result_i[DATA_W-1:0];
                        div_start_o <= DivStop;
                        done_q      <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                ST_CANCEL: begin
                    if (cancel_cnt == CANCEL_LAST) begin
                        div_annul_o <= 1'b0;
                        cancel_cnt  <= 2'd0;
                        state       <= ST_IDLE;
                    end else begin
                        cancel_cnt <= cancel_cnt + 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl with a behavioural divider of random latency.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_div_valid = 1'b0;
    logic        ex_div_signed = 1'b0;
    logic [31:0] ex_opa = '0;
    logic [31:0] ex_opb = '0;
    logic        flush_i = 1'b0;
    logic        stall_req_o, div_start_o, div_annul_o, div_signed_o;
    logic [31:0] div_op1_o, div_op2_o;
    logic [63:0] div_result = '0;
    logic        div_ready = 1'b0;
    logic        hilo_we_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;
    int issued = 0;
    int pushed = 0;
    int starts = 0;
    int we_count = 0;
    int tb_lat = 1;
    int dcnt = 0;
    logic prev_we = 1'b0;
    logic prev_start = 1'b0;
    logic [63:0] sb[$];
    logic [63:0] mon_exp;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    div_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ex_div_valid(ex_div_valid), .ex_div_signed(ex_div_signed),
        .ex_opa(ex_opa), .ex_opb(ex_opb), .flush_i(flush_i),
        .stall_req_o(stall_req_o), .div_start_o(div_start_o),
        .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
        .div_result_i(div_result), .div_ready_i(div_ready),
        .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    // Truncating division; divide-by-zero yields zero remainder and quotient.
    function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b, logic sgn);
        longint sa, sb2, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa  = longint'($signed(a));
            sb2 = longint'($signed(b));
        end else begin
            sa  = longint'({32'd0, a});
            sb2 = longint'({32'd0, b});
        end
        q = sa / sb2;
        r = sa % sb2;
        return {r[31:0], q[31:0]};
    endfunction

    // Divider: result appears tb_lat cycles after start, held until start drops.
    always @(posedge clk) begin
        if (rst || !div_start_o) begin
            dcnt      <= 0;
            div_ready <= 1'b0;
        end else if (dcnt >= tb_lat) begin
            div_ready  <= 1'b1;
            div_result <= ref_div(div_op1_o, div_op2_o, div_signed_o);
        end else begin
            dcnt <= dcnt + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every HI/LO write.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (div_start_o && !prev_start) starts++;
            if (hilo_we_o) begin
                we_count++;
                chk("hilo_we_single", 64'(prev_we), 64'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL hilo_unexpected actual=1 required=0");
                end else begin
                    mon_exp = sb.pop_front();
                    chk("sb_hi", 64'(hi_o), 64'(mon_exp[63:32]));
                    chk("sb_lo", 64'(lo_o), 64'(mon_exp[31:0]));
                    last_hi = mon_exp[63:32];
                    last_lo = mon_exp[31:0];
                end
            end
        end
        prev_we    = hilo_we_o;
        prev_start = div_start_o;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int lat, input bit push);
        @(negedge clk);
        ex_div_valid  = 1'b1;
        ex_div_signed = sgn;
        ex_opa        = a;
        ex_opb        = b;
        tb_lat        = lat;
        issued++;
        if (push) begin
            sb.push_back(ref_div(a, b, sgn));
            pushed++;
        end
        #1;
        chk("issue_stall", 64'(stall_req_o), 64'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!stall_req_o) break;
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL done_timeout actual=%0d required<=500", n);
                break;
            end
        end
        chk("done_start", 64'(div_start_o), 64'd0);
        chk("done_we", 64'(hilo_we_o), 64'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        ex_div_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int s0;
        logic [31:0] ra, rb;
        logic        rs;
        int          rl;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_stall", 64'(stall_req_o), 64'd0);
        chk("rst_start", 64'(div_start_o), 64'd0);
        chk("rst_annul", 64'(div_annul_o), 64'd0);
        chk("rst_ops", {div_op1_o, div_op2_o}, 64'd0);
        chk("rst_hilo", {hi_o, lo_o}, 64'd0);
        chk("rst_we", 64'(hilo_we_o), 64'd0);

        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 5, 1'b1);
        wait_done();
        chk("signed_hi", 64'(hi_o), 64'hFFFF_FFFF);
        chk("signed_lo", 64'(lo_o), 64'hFFFF_FFFD);
        idle();

        issue(32'd100, 32'd7, 1'b0, 8, 1'b1);
        wait_done();
        chk("unsigned_hi", 64'(hi_o), 64'd2);
        chk("unsigned_lo", 64'(lo_o), 64'd14);
        idle();
        #1;
        chk("after_done_start", 64'(div_start_o), 64'd0);

        // Flush in the 10th WAIT cycle of a long divide.
        issue(32'd12345, 32'd17, 1'b0, 40, 1'b0);
        repeat (10) @(negedge clk);
        flush_i      = 1'b1;
        ex_div_valid = 1'b0;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk("cancel1_annul", 64'(div_annul_o), 64'd1);
        chk("cancel1_start", 64'(div_start_o), 64'd0);
        chk("cancel1_stall", 64'(stall_req_o), 64'd0);
        chk("cancel1_we", 64'(hilo_we_o), 64'd0);
        chk("cancel_hilo", {hi_o, lo_o}, {last_hi, last_lo});
        @(negedge clk);
        #1;
        chk("cancel2_annul", 64'(div_annul_o), 64'd1);
        @(negedge clk);
        #1;
        chk("cancel_end_annul", 64'(div_annul_o), 64'd0);
        chk("cancel_end_start", 64'(div_start_o), 64'd0);

        issue(32'd9, 32'd3, 1'b0, 3, 1'b1);
        wait_done();
        chk("after_cancel_lo", 64'(lo_o), 64'd3);
        chk("after_cancel_hi", 64'(hi_o), 64'd0);
        idle();

        issue(32'd77, 32'd0, 1'b1, 0, 1'b1);
        wait_done();
        chk("div0_hilo", {hi_o, lo_o}, 64'd0);
        idle();

        // Back-to-back with valid held through DONE.
        @(negedge clk);
        #3;
        s0 = starts;
        issue(32'd1000, 32'd33, 1'b0, 4, 1'b1);
        wait_done();
        issue(32'hFFFF_FC18, 32'd7, 1'b1, 2, 1'b1);
        wait_done();
        idle();
        @(negedge clk);
        #3;
        chk("b2b_starts", 64'(starts - s0), 64'd2);

        // Flush while idle: nothing issues.
        @(negedge clk);
        ex_div_valid = 1'b1;
        flush_i      = 1'b1;
        #1;
        chk("idle_flush_stall", 64'(stall_req_o), 64'd0);
        @(negedge clk);
        ex_div_valid = 1'b0;
        flush_i      = 1'b0;
        #1;
        chk("idle_flush_start", 64'(div_start_o), 64'd0);

        // Reset mid-WAIT.
        issue(32'd5555, 32'd11, 1'b1, 40, 1'b0);
        repeat (5) @(negedge clk);
        rst          = 1'b1;
        ex_div_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_start", 64'(div_start_o), 64'd0);
        chk("midrst_stall", 64'(stall_req_o), 64'd0);
        chk("midrst_signed", 64'(div_signed_o), 64'd0);
        chk("midrst_ops", {div_op1_o, div_op2_o}, 64'd0);
        chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
        last_hi = '0;
        last_lo = '0;
        issue(32'd250, 32'd12, 1'b0, 6, 1'b1);
        wait_done();
        chk("postrst_lo", 64'(lo_o), 64'd20);
        chk("postrst_hi", 64'(hi_o), 64'd10);
        idle();

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            rl = (rb == 32'd0) ? 0 : $urandom_range(1, 12);
            issue(ra, rb, rs, rl, 1'b1);
            wait_done();
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();
        repeat (4) @(negedge clk);
        #3;

        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("start_pulses", 64'(starts), 64'(issued));
        chk("hilo_count", 64'(we_count), 64'(pushed));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
